// File: rtl/eth_gen_pkg.sv
// Shared types and codes for the MII/XGMII frame generator and its scheduler.
package eth_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_SOF,
        IN_FRAME,
        GAP,
        DONE
    } sched_state_t;

    localparam logic [7:0] START_CODE_DEF     = 8'hFB;
    localparam logic [7:0] TERMINATE_CODE_DEF = 8'hFD;
    localparam logic [7:0] IDLE_CODE          = 8'h07;

    // Any set bit in the lane's ctrl byte marks the data byte as a control character.
    function automatic logic is_ctrl_char(input logic [7:0] ctrl);
        return ctrl != 8'h00;
    endfunction

endpackage

// File: rtl/mii_gen_timer.sv
// Loadable up/down cycle counter; tc flags count==limit when counting up, count==0 when down.
module mii_gen_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign tc = up ? (count == limit) : (count == '0);

endmodule

// File: rtl/mii_gen_scheduler.sv
// Run sequencer for the frame generator: start pulses, scenario codes, inter-frame gap,
// frame tracking by snooping START/TERMINATE characters, and timeout accounting.
module mii_gen_scheduler
    import eth_gen_pkg::*;
#(
    parameter int         CNT_W          = 16,
    parameter int         GAP_W          = 8,
    parameter int         N_SCEN         = 4,
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [7:0] START_CODE     = START_CODE_DEF,
    parameter logic [7:0] TERMINATE_CODE = TERMINATE_CODE_DEF
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [CNT_W-1:0]      i_num_frames,
    input  logic [GAP_W-1:0]      i_gap_cycles,
    input  logic [8*N_SCEN-1:0]   i_scen_table,
    input  logic [7:0]            i_gen_data,
    input  logic [7:0]            i_gen_ctrl,
    output logic                  o_start,
    output logic [7:0]            o_interrupt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_frame_cnt,
    output logic [7:0]            o_err_cnt,
    output logic                  o_timeout_err
);

    localparam int IDX_W = (N_SCEN > 1) ? $clog2(N_SCEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int TMR_W = (GAP_W > TO_W) ? GAP_W : TO_W;
    localparam logic [TMR_W-1:0] TO_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    sched_state_t     state, state_d;
    logic             en_sync, en_q;
    logic [CNT_W-1:0] num_q, num_d, attempts, attempts_d, frame_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_len;
    logic [IDX_W-1:0] idx, idx_d;
    logic [7:0]       err_d, int_d;
    logic             terr_d, frame_end, timeout;
    logic             tmr_clr, tmr_load, tmr_en, tmr_up, tmr_tc;

    wire sof       = is_ctrl_char(i_gen_ctrl) && (i_gen_data == START_CODE);
    wire eof       = is_ctrl_char(i_gen_ctrl) && (i_gen_data == TERMINATE_CODE);
    wire run_start = en_sync & ~en_q;

    // A programmed gap of 0 still costs one pass-through cycle in GAP.
    assign gap_len = (gap_q == '0) ? '0 : gap_q - 1'b1;
    assign tmr_up  = (state != GAP);

    mii_gen_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (i_rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (TMR_W'(gap_len)),
        .en       (tmr_en),
        .up       (tmr_up),
        .limit    (TO_LIMIT),
        .tc       (tmr_tc)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        num_d      = num_q;
        gap_d      = gap_q;
        idx_d      = idx;
        attempts_d = attempts;
        frame_d    = o_frame_cnt;
        err_d      = o_err_cnt;
        terr_d     = o_timeout_err;
        frame_end  = 1'b0;
        timeout    = 1'b0;
        tmr_clr    = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        int_d      = 8'h00;

        unique case (state)
            IDLE: begin
                if (run_start) begin
                    state_d    = LAUNCH;
                    num_d      = i_num_frames;
                    gap_d      = i_gap_cycles;
                    idx_d      = '0;
                    attempts_d = '0;
                    frame_d    = '0;
                    err_d      = '0;
                    terr_d     = 1'b0;
                end
            end
            LAUNCH: begin
                state_d = WAIT_SOF;
                tmr_clr = 1'b1;
            end
            WAIT_SOF: begin
                if (sof) begin
                    state_d = IN_FRAME;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    timeout = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            IN_FRAME: begin
                if (eof) begin
                    frame_end = 1'b1;
                    frame_d   = (&o_frame_cnt) ? o_frame_cnt : o_frame_cnt + 1'b1;
                end else if (tmr_tc) begin
                    timeout = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    state_d = ((num_q != '0 && attempts == num_q) || !en_sync) ? DONE : LAUNCH;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A timed-out frame still consumes its scenario slot and counts toward the run length.
        if (frame_end || timeout) begin
            state_d    = GAP;
            tmr_load   = 1'b1;
            idx_d      = idx + 1'b1;
            attempts_d = attempts + 1'b1;
        end
        if (timeout) begin
            terr_d = 1'b1;
            err_d  = (&o_err_cnt) ? o_err_cnt : o_err_cnt + 1'b1;
        end

        if (state_d == LAUNCH) begin
            int_d = i_scen_table[8*idx_d +: 8];
        end else if (state_d == WAIT_SOF || state_d == IN_FRAME) begin
            int_d = o_interrupt;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            en_sync       <= 1'b0;
            en_q          <= 1'b0;
            num_q         <= '0;
            gap_q         <= '0;
            idx           <= '0;
            attempts      <= '0;
            o_start       <= 1'b0;
            o_interrupt   <= 8'h00;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_frame_cnt   <= '0;
            o_err_cnt     <= 8'h00;
            o_timeout_err <= 1'b0;
        end else begin
            state         <= state_d;
            en_sync       <= i_enable;
            en_q          <= en_sync;
            num_q         <= num_d;
            gap_q         <= gap_d;
            idx           <= idx_d;
            attempts      <= attempts_d;
            o_start       <= (state_d == LAUNCH);
            o_interrupt   <= int_d;
            o_busy        <= (state_d != IDLE);
            o_done        <= (state_d == DONE);
            o_frame_cnt   <= frame_d;
            o_err_cnt     <= err_d;
            o_timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_mii_gen_scheduler.sv
// Scoreboard bench for mii_gen_scheduler with a behavioural frame generator attached.
module tb_mii_gen_scheduler;

    localparam int CNT_W  = 16;
    localparam int GAP_W  = 8;
    localparam int N_SCEN = 4;

    logic                clk = 1'b0;
    logic                i_rst;
    logic                i_enable;
    logic [CNT_W-1:0]    i_num_frames;
    logic [GAP_W-1:0]    i_gap_cycles;
    logic [8*N_SCEN-1:0] i_scen_table;
    logic [7:0]          i_gen_data;
    logic [7:0]          i_gen_ctrl;
    logic                o_start;
    logic [7:0]          o_interrupt;
    logic                o_busy;
    logic                o_done;
    logic [CNT_W-1:0]    o_frame_cnt;
    logic [7:0]          o_err_cnt;
    logic                o_timeout_err;

    mii_gen_scheduler #(.CNT_W(CNT_W), .GAP_W(GAP_W), .N_SCEN(N_SCEN)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_num_frames  (i_num_frames),
        .i_gap_cycles  (i_gap_cycles),
        .i_scen_table  (i_scen_table),
        .i_gen_data    (i_gen_data),
        .i_gen_ctrl    (i_gen_ctrl),
        .o_start       (o_start),
        .o_interrupt   (o_interrupt),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_frame_cnt   (o_frame_cnt),
        .o_err_cnt     (o_err_cnt),
        .o_timeout_err (o_timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] exp_q[$];
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         eof_cyc, en_cyc, prev_start_cyc;
    bit         eof_valid = 0;
    bit         first_pending = 0;
    bit         prev_start_valid = 0;
    int         exp_gap_lat = 0;
    int         exp_period = 0;
    bit         gen_stall = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Generator model: after each o_start, a START char, 8 payload bytes, then TERMINATE.
    // In stall mode it never sends START, only a START byte with ctrl=0 and a stray TERMINATE.
    initial begin : generator
        i_gen_ctrl = 8'h01;
        i_gen_data = 8'h07;
        forever begin
            @(negedge clk);
            if (o_start && !i_rst) begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (i_rst) break;
                    i_gen_ctrl = 8'h01;
                    i_gen_data = 8'h07;
                    if (gen_stall) begin
                        if (i == 3) begin i_gen_ctrl = 8'h00; i_gen_data = 8'hFB; end
                        if (i == 5) begin i_gen_ctrl = 8'h01; i_gen_data = 8'hFD; end
                    end else if (i == 1) begin
                        i_gen_data = 8'hFB;
                    end else if (i >= 2 && i <= 9) begin
                        i_gen_ctrl = 8'h00;
                        i_gen_data = 8'($urandom_range(0, 255));
                    end else if (i == 10) begin
                        i_gen_data = 8'hFD;
                        eof_cyc    = cyc;
                        eof_valid  = 1;
                    end
                end
                i_gen_ctrl = 8'h01;
                i_gen_data = 8'h07;
            end
        end
    end

    initial begin : monitor
        bit         done_prev;
        logic [7:0] exp_v;
        done_prev = 0;
        forever begin
            @(negedge clk);
            if (done_prev) check("busy_after_done", o_busy, 0);
            done_prev = o_done;
            if (o_done) done_cnt++;
            if (o_start) begin
                check("busy_at_start", o_busy, 1);
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("interrupt", o_interrupt, exp_v);
                if (first_pending) begin
                    check("enable_to_start", cyc - en_cyc, 2);
                    first_pending = 0;
                end
                if (eof_valid) begin
                    check("eof_to_start", cyc - eof_cyc, exp_gap_lat);
                    eof_valid = 0;
                end
                if (prev_start_valid && exp_period != 0)
                    check("start_period", cyc - prev_start_cyc, exp_period);
                prev_start_valid = 1;
                prev_start_cyc   = cyc;
                start_cnt++;
            end
        end
    end

    task automatic start_run(input int num, input int gap, input logic [31:0] tbl,
                             input bit stall, input int n_exp);
        int gap_eff;
        @(negedge clk);
        gap_eff          = (gap == 0) ? 1 : gap;
        i_num_frames     = CNT_W'(num);
        i_gap_cycles     = GAP_W'(gap);
        i_scen_table     = tbl;
        gen_stall        = stall;
        exp_gap_lat      = gap_eff + 1;
        exp_period       = stall ? 1 + 256 + gap_eff : 0;
        eof_valid        = 0;
        prev_start_valid = 0;
        first_pending    = 1;
        for (int k = 0; k < n_exp; k++) exp_q.push_back(tbl[8*(k % N_SCEN) +: 8]);
        i_enable = 1'b1;
        en_cyc   = cyc;
    endtask

    task automatic finish_run(input int d0, input int budget, input int frames,
                              input int errs, input bit terr);
        int waited = 0;
        while (done_cnt == d0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("frame_cnt", o_frame_cnt, frames);
        check("err_cnt", o_err_cnt, errs);
        check("timeout_err", o_timeout_err, terr);
        check("busy_idle", o_busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        i_enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int waited = 0;
        while (start_cnt < target && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin : stimulus
        int d0, s0;
        i_rst        = 1'b1;
        i_enable     = 1'b0;
        i_num_frames = '0;
        i_gap_cycles = '0;
        i_scen_table = '0;
        repeat (3) @(negedge clk);
        check("rst_start", o_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_interrupt", o_interrupt, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
        check("rst_err_cnt", o_err_cnt, 0);
        check("rst_timeout_err", o_timeout_err, 0);
        i_rst = 1'b0;
        repeat (3) @(negedge clk);

        // Three-frame run, 12-cycle gap.
        d0 = done_cnt;
        start_run(3, 12, 32'h03_02_01_00, 0, 3);
        finish_run(d0, 2000, 3, 0, 0);

        // Continuous run, enable dropped during frame 5.
        d0 = done_cnt;
        s0 = start_cnt;
        start_run(0, 3, 32'h44_33_22_11, 0, 5);
        wait_starts(s0 + 5, 2000);
        i_enable = 1'b0;
        finish_run(d0, 2000, 5, 0, 0);

        // Stalled generator: every frame times out; START byte with ctrl=0 must be ignored.
        d0 = done_cnt;
        start_run(2, 4, 32'hC3_C2_C1_C0, 1, 2);
        finish_run(d0, 2000, 0, 2, 1);

        // Zero gap, scenario index wraps after entry 3.
        d0 = done_cnt;
        start_run(6, 0, 32'hA3_A2_A1_A0, 0, 6);
        finish_run(d0, 2000, 6, 0, 0);

        // Reset asserted inside frame 2, then a clean re-run.
        d0 = done_cnt;
        s0 = start_cnt;
        start_run(3, 2, 32'h88_77_66_55, 0, 3);
        wait_starts(s0 + 2, 2000);
        repeat (4) @(negedge clk);
        check("pre_rst_frame_cnt", o_frame_cnt, 1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_start", o_start, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_interrupt", o_interrupt, 0);
        check("mid_rst_frame_cnt", o_frame_cnt, 0);
        check("mid_rst_err_cnt", o_err_cnt, 0);
        check("mid_rst_timeout_err", o_timeout_err, 0);
        i_enable = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 0);
        d0 = done_cnt;
        start_run(2, 1, 32'h88_77_66_55, 0, 2);
        finish_run(d0, 2000, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
